// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// The round-robin pick function is also used by the read-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int STAT_W   = 16;
  localparam int RR_MAX_N = 64;

  // First valid index strictly after last_id, wrapping modulo n.
  // Returns last_id when nothing is valid.
  function automatic int rr_pick(input logic [RR_MAX_N-1:0] valid,
                                 input int                  last_id,
                                 input int                  n);
    int pick;
    int idx;
    pick = last_id;
    // Scanning downward lets the closest candidate overwrite farther ones.
    for (int k = RR_MAX_N; k >= 1; k--) begin
      if (k <= n) begin
        idx = last_id + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Purely combinational round-robin priority encoder, N-parameterised.
module rr_pick_comb
  import fifo_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int GW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [GW-1:0] last_id,
  output logic [GW-1:0] pick,
  output logic          any
);

  always_comb begin
    pick = GW'(rr_pick(RR_MAX_N'(valid), 32'(last_id), N));
    any  = |valid;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-granular arbiter sharing the async FIFO write port.
// Optional per-requester beat statistics when WRARB_STATS_EN is defined.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int DW        = 8,
  parameter  int MAX_BURST = 16,
  parameter  int IDLE_TO   = 8,
  localparam int GW        = $clog2(N),
  localparam int BW        = $clog2(MAX_BURST + 1),
  localparam int IW        = $clog2(IDLE_TO + 1)
) (
  input  logic            wrclk,
  input  logic            wrrst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  input  logic            full,
  output logic            wren,
  output logic [DW-1:0]   wrdata,
  output logic [N-1:0]    grant,
  output logic            busy
`ifdef WRARB_STATS_EN
  ,
  input  logic [GW-1:0]     stat_sel,
  output logic [STAT_W-1:0] stat_cnt
`endif
);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] last_id_q, last_id_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [IW-1:0] idle_q, idle_d;

  logic [GW-1:0] pick_id;
  logic          any_valid;
  logic          g_valid;
  logic          g_last;
  logic          acc;

  rr_pick_comb #(.N(N)) u_pick (
    .valid   (req_valid),
    .last_id (last_id_q),
    .pick    (pick_id),
    .any     (any_valid)
  );

  // In BURST the granted index is always last_id, since it is loaded on entry.
  assign busy      = (state_q == ST_BURST);
  assign grant     = grant_q;
  assign g_valid   = req_valid[last_id_q];
  assign g_last    = req_last[last_id_q];
  assign acc       = busy & g_valid & ~full;
  assign wren      = acc;
  assign req_ready = acc ? grant_q : '0;
  assign wrdata    = busy ? req_data[last_id_q*DW +: DW] : '0;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no latch is inferred.
    state_d   = state_q;
    last_id_d = last_id_q;
    grant_d   = grant_q;
    beat_d    = beat_q;
    idle_d    = idle_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d   = ST_BURST;
          last_id_d = pick_id;
          grant_d   = N'(1) << pick_id;
          beat_d    = '0;
          idle_d    = '0;
        end
      end
      ST_BURST: begin
        if (acc) begin
          beat_d = beat_q + 1'b1;
          idle_d = '0;
          if (g_last || (beat_q == BW'(MAX_BURST - 1))) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else if (!full) begin
          // A FIFO stall freezes the timeout; only requester silence counts.
          if (idle_q == IW'(IDLE_TO - 1)) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wrclk or negedge wrrst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!wrrst) begin
      state_q   <= ST_IDLE;
      last_id_q <= GW'(N - 1);
      grant_q   <= '0;
      beat_q    <= '0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      grant_q   <= grant_d;
      beat_q    <= beat_d;
      idle_q    <= idle_d;
    end
  end

`ifdef WRARB_STATS_EN
  logic [STAT_W-1:0] stat_q [N];

  always_ff @(posedge wrclk or negedge wrrst) begin
    // NOTE: this is a handful of flops, not a RAM, so it is reset like any register.
    if (!wrrst) begin
      for (int i = 0; i < N; i++) stat_q[i] <= '0;
      stat_cnt <= '0;
    end else begin
      if (acc && (stat_q[last_id_q] != '1)) stat_q[last_id_q] <= stat_q[last_id_q] + 1'b1;
      stat_cnt <= (32'(stat_sel) < N) ? stat_q[stat_sel] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: randomized requesters and FIFO full, compared every
// cycle against a behavioural arbiter model, plus directed literal checks.
module tb_fifo_write_arbiter;

  localparam int N         = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 16;
  localparam int IDLE_TO   = 8;

  logic            wrclk     = 1'b0;
  logic            wrrst     = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic            full      = 1'b0;
  logic [N-1:0]    req_ready;
  logic            wren;
  logic [DW-1:0]   wrdata;
  logic [N-1:0]    grant;
  logic            busy;

  fifo_write_arbiter #(
    .N(N), .DW(DW), .MAX_BURST(MAX_BURST), .IDLE_TO(IDLE_TO)
  ) dut (
    .wrclk     (wrclk),
    .wrrst     (wrrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .full      (full),
    .wren      (wren),
    .wrdata    (wrdata),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 wrclk = ~wrclk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the end of the run");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Behavioural model: who holds the port, beats taken, silent cycles.
  bit m_busy;
  int m_g, m_last, m_beats, m_idle;

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_last = N - 1; m_beats = 0; m_idle = 0;
  endtask

  task automatic model_advance();
    if (!m_busy) begin
      if (req_valid != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (req_valid[(m_last + k) % N]) begin
            m_g = (m_last + k) % N;
            break;
          end
        end
        m_last = m_g; m_busy = 1; m_beats = 0; m_idle = 0;
      end
    end else if (req_valid[m_g] && !full) begin
      m_beats++;
      m_idle = 0;
      if (req_last[m_g] || m_beats == MAX_BURST) m_busy = 0;
    end else if (!full) begin
      m_idle++;
      if (m_idle == IDLE_TO) m_busy = 0;
    end
  endtask

  // Requester generators.
  bit            en       [N];
  bit            has      [N];
  bit            cur_last [N];
  logic [DW-1:0] cur_data [N];
  int            seq [N], bpos [N], avail [N], last_every [N];
  int            valid_pct, full_pct;
  bit            full_force;

  task automatic gen_clear();
    for (int i = 0; i < N; i++) begin
      en[i] = 0; has[i] = 0; cur_last[i] = 0; seq[i] = 0; bpos[i] = 0;
      avail[i] = -1; last_every[i] = 0;
    end
    valid_pct = 100; full_pct = 0; full_force = 0;
  endtask

  task automatic consume(input logic [N-1:0] acc);
    for (int i = 0; i < N; i++) begin
      if (has[i] && acc[i]) begin
        seq[i]++;
        bpos[i] = cur_last[i] ? 0 : bpos[i] + 1;
        if (avail[i] > 0) avail[i]--;
        has[i] = 0;
      end
    end
  endtask

  task automatic produce();
    for (int i = 0; i < N; i++) begin
      if (!has[i] && en[i] && avail[i] != 0 && int'($urandom_range(99)) < valid_pct) begin
        has[i]      = 1;
        cur_data[i] = DW'(i * 64 + seq[i] % 64);
        if (last_every[i] > 0)       cur_last[i] = (bpos[i] >= last_every[i] - 1);
        else if (last_every[i] == 0) cur_last[i] = ($urandom_range(3) == 0);
        else                         cur_last[i] = 0;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = has[i];
      req_last[i]            = has[i] ? cur_last[i] : 1'($urandom);
      req_data[i*DW +: DW]   = has[i] ? cur_data[i] : DW'($urandom);
    end
    full = full_force || (int'($urandom_range(99)) < full_pct);
  endtask

  // Observations of the DUT, used by the directed literal checks.
  int            obs_beats [N];
  int            obs_gcyc  [N];
  logic [DW-1:0] obs_data  [$];
  int            obs_grants[$];
  int            obs_len   [$];
  int            cur_len, cyc, first_grant_cyc;
  logic [N-1:0]  prev_grant;

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic clear_obs();
    for (int i = 0; i < N; i++) begin obs_beats[i] = 0; obs_gcyc[i] = 0; end
    obs_data.delete(); obs_grants.delete(); obs_len.delete();
    cur_len = 0; cyc = 0; first_grant_cyc = -1; prev_grant = grant;
  endtask

  task automatic observe();
    if (wren) begin
      for (int i = 0; i < N; i++) if (req_ready[i]) obs_beats[i]++;
      obs_data.push_back(wrdata);
      cur_len++;
    end
    for (int i = 0; i < N; i++) obs_gcyc[i] += int'(grant[i]);
    if (grant != '0 && prev_grant == '0) begin
      obs_grants.push_back(oh_idx(grant));
      if (first_grant_cyc < 0) first_grant_cyc = cyc;
    end
    if (grant == '0 && prev_grant != '0) begin
      obs_len.push_back(cur_len);
      cur_len = 0;
    end
    prev_grant = grant;
    cyc++;
  endtask

  // One clock: compare at negedge, advance model at posedge, drive at posedge+1.
  task automatic cycle();
    logic [N-1:0]  e_grant, e_ready;
    logic [DW-1:0] e_data;
    bit            e_acc;
    @(negedge wrclk);
    e_grant = m_busy ? (N'(1) << m_g) : '0;
    e_acc   = m_busy && req_valid[m_g] && !full;
    e_ready = e_acc ? e_grant : '0;
    e_data  = m_busy ? req_data[m_g*DW +: DW] : '0;
    check("busy", busy, m_busy);
    check("grant", grant, e_grant);
    check("wren", wren, e_acc);
    check("req_ready", req_ready, e_ready);
    check("wrdata", wrdata, e_data);
    observe();
    @(posedge wrclk);
    if (!wrrst) model_reset();
    else        model_advance();
    #1;
    consume(e_ready);
    produce();
    drive();
  endtask

  task automatic run(input int n);
    for (int t = 0; t < n; t++) cycle();
  endtask

  // Reset asserted between edges; outputs must drop without waiting for a clock.
  task automatic apply_reset(input bit clr);
    #2;
    wrrst = 1'b0;
    #1;
    check("rst_wren", wren, 1'b0);
    check("rst_grant", grant, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", req_ready, '0);
    model_reset();
    if (clr) begin gen_clear(); drive(); end
    run(2);
    wrrst = 1'b1;
  endtask

  task automatic start();
    produce();
    drive();
    clear_obs();
  endtask

  initial begin
    int exp_g3 [5] = '{0, 1, 2, 3, 0};
    int exp_g4 [3] = '{1, 2, 1};
    int base;

    gen_clear();
    model_reset();
    drive();
    apply_reset(1'b1);

    // 3-beat burst from requester 0.
    apply_reset(1'b1);
    en[0] = 1; last_every[0] = 3; avail[0] = 3;
    start();
    run(8);
    check("s2_latency", first_grant_cyc, 1);
    check("s2_beats", obs_beats[0], 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("s2_data%0d", i), (i < obs_data.size()) ? obs_data[i] : 'x, DW'(i));
    check("s2_idle", busy, 1'b0);

    // All requesters, 2-beat bursts: rotation with one dead cycle each.
    apply_reset(1'b1);
    for (int i = 0; i < N; i++) begin en[i] = 1; last_every[i] = 2; end
    start();
    run(15);
    check("s3_ngrants", obs_grants.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("s3_grant%0d", i), (i < obs_grants.size()) ? obs_grants[i] : -1, exp_g3[i]);
    check("s3_beats0", obs_beats[0], 4);
    for (int i = 1; i < N; i++) check($sformatf("s3_beats%0d", i), obs_beats[i], 2);
    check("s3_model_last", m_last, 0);

    // Requester 1 never signals last: forced split at MAX_BURST, then 2 served.
    apply_reset(1'b1);
    en[1] = 1; last_every[1] = -1;
    en[2] = 1; last_every[2] = 2;
    start();
    run(24);
    for (int i = 0; i < 3; i++)
      check($sformatf("s4_grant%0d", i), (i < obs_grants.size()) ? obs_grants[i] : -1, exp_g4[i]);
    check("s4_len0", (obs_len.size() > 0) ? obs_len[0] : -1, MAX_BURST);
    check("s4_len1", (obs_len.size() > 1) ? obs_len[1] : -1, 2);

    // Long FIFO stall mid-burst keeps the grant; no beat lost or duplicated.
    apply_reset(1'b1);
    en[0] = 1; last_every[0] = 8; avail[0] = 8;
    start();
    run(4);
    base = obs_beats[0];
    full_force = 1; full = 1'b1;
    run(20);
    check("s5_stall_beats", obs_beats[0] - base, 0);
    check("s5_stall_grant", grant, 4'b0001);
    check("s5_stall_busy", busy, 1'b1);
    full_force = 0; full = 1'b0;
    run(10);
    check("s5_beats", obs_beats[0], 8);
    check("s5_nbursts", obs_len.size(), 1);
    for (int i = 0; i < 8; i++)
      check($sformatf("s5_data%0d", i), (i < obs_data.size()) ? obs_data[i] : 'x, DW'(i));

    // Requester 0 goes silent: released after IDLE_TO cycles, 2 granted next.
    apply_reset(1'b1);
    en[0] = 1; last_every[0] = -1; avail[0] = 2;
    en[2] = 1; last_every[2] = 4;
    start();
    run(16);
    check("s6_hold_cycles", obs_gcyc[0], 2 + IDLE_TO);
    check("s6_ngrants", obs_grants.size(), 2);
    check("s6_grant1", (obs_grants.size() > 1) ? obs_grants[1] : -1, 2);
    check("s6_len0", (obs_len.size() > 0) ? obs_len[0] : -1, 2);
    check("s6_model_g", m_g, 2);

    // Reset mid-burst; afterwards the lowest valid index wins.
    apply_reset(1'b1);
    for (int i = 0; i < N; i++) begin en[i] = 1; last_every[i] = -1; end
    start();
    run(5);
    check("s7_pre_wren", wren, 1'b1);
    apply_reset(1'b0);
    clear_obs();
    run(3);
    check("s7_first_grant", (obs_grants.size() > 0) ? obs_grants[0] : -1, 0);
    check("s7_latency", first_grant_cyc, 1);

    // Randomized traffic against the model.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        en[i]         = ($urandom_range(3) != 0);
        last_every[i] = int'($urandom_range(6)) - 1;
        avail[i]      = -1;
      end
      valid_pct  = 30 + int'($urandom_range(70));
      full_pct   = int'($urandom_range(40));
      full_force = 0;
      if (r % 7 == 3) apply_reset(1'b0);
      run(200);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
